// File: rtl/tmss_pkg.sv
// Shared types and constants for the TMSS unlock master: state encoding,
// the fixed unlock addresses/data, and the per-op write descriptor.
package tmss_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ASSERT,
    RELEASE,
    DONE,
    ABORT
  } tmss_state_e;

  localparam logic [22:0] TMSS_VA_SEGA_HI = 23'h50A000;
  localparam logic [22:0] TMSS_VA_SEGA_LO = 23'h50A001;
  localparam logic [22:0] TMSS_VA_LOCK    = 23'h50A080;

  localparam logic [15:0] TMSS_VD_SEGA_HI = 16'h5345;
  localparam logic [15:0] TMSS_VD_SEGA_LO = 16'h4741;

  localparam logic [1:0] OP_LAST = 2'd2;

  typedef struct packed {
    logic [22:0] va;
    logic [15:0] vd;
    logic        uds_n;
  } tmss_op_t;

  // The lock write is a byte write to the low lane only.
  function automatic tmss_op_t tmss_op_decode(input logic [1:0] op, input logic cart);
    tmss_op_t c;
    c.va    = TMSS_VA_SEGA_HI;
    c.vd    = TMSS_VD_SEGA_HI;
    c.uds_n = 1'b0;
    case (op)
      2'd1: begin
        c.va = TMSS_VA_SEGA_LO;
        c.vd = TMSS_VD_SEGA_LO;
      end
      2'd2: begin
        c.va    = TMSS_VA_LOCK;
        c.vd    = {15'd0, cart};
        c.uds_n = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tmss_bus_wr.sv
// One 68k-style write cycle: address/data setup, strobes until DTACK low,
// release until DTACK high, with a per-phase timeout.
module tmss_bus_wr
  import tmss_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic        MCLK,
  input  logic        RESn,
  input  logic        go,
  input  tmss_op_t    op_cfg,
  input  logic        DTACK,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic [22:0] VA,
  output logic [15:0] VD_o,
  output logic        VD_oe,
  output logic        wr_ok,
  output logic        wr_tmo
);

  // state   | meaning
  // IDLE    | bus released, waiting for go
  // ADDR    | VA/VD driven, strobes high, counting setup cycles
  // ASSERT  | AS and op strobes low, waiting for DTACK low
  // RELEASE | strobes high, waiting for DTACK high

  localparam int              CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_MAX   = CNT_W'(TIMEOUT);
  localparam logic [3:0]       SETUP_LAST = 4'(SETUP_CYC - 1);

  tmss_state_e      state, state_next;
  logic [3:0]       setup_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             uds_n_q;
  logic             load;
  logic             on_bus_next;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_LAST);
  // DTACK is checked before the timeout, so an ack on the last cycle still counts.
  assign wr_ok   = (state == RELEASE) && DTACK;
  assign wr_tmo  = tmo_hit && (((state == ASSERT) && DTACK) || ((state == RELEASE) && !DTACK));

  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_next = ADDR;
          load       = 1'b1;
        end
      end
      ADDR: begin
        if (setup_cnt == 4'd0) state_next = ASSERT;
      end
      ASSERT: begin
        if (!DTACK)       state_next = RELEASE;
        else if (tmo_hit) state_next = IDLE;
      end
      RELEASE: begin
        if (DTACK) begin
          if (go) begin
            state_next = ADDR;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (tmo_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    on_bus_next = (state_next == ADDR) || (state_next == ASSERT) || (state_next == RELEASE);
  end

  always_ff @(posedge MCLK or negedge RESn) begin
    if (!RESn) begin
      state     <= IDLE;
      setup_cnt <= 4'd0;
      tmo_cnt   <= '0;
      uds_n_q   <= 1'b1;
      AS        <= 1'b1;
      UDS       <= 1'b1;
      LDS       <= 1'b1;
      RW        <= 1'b1;
      VA        <= '0;
      VD_o      <= '0;
      VD_oe     <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        VA        <= op_cfg.va;
        VD_o      <= op_cfg.vd;
        uds_n_q   <= op_cfg.uds_n;
        setup_cnt <= SETUP_LAST;
      end else if ((state == ADDR) && (setup_cnt != 4'd0)) begin
        setup_cnt <= setup_cnt - 4'd1;
      end
      if (state_next != state) begin
        tmo_cnt <= '0;
      end else if (((state == ASSERT) || (state == RELEASE)) && (tmo_cnt != TMO_MAX)) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
      AS    <= (state_next != ASSERT);
      LDS   <= (state_next != ASSERT);
      UDS   <= (state_next != ASSERT) || uds_n_q;
      RW    <= !on_bus_next;
      VD_oe <= on_bus_next;
    end
  end

endmodule

// File: rtl/tmss_unlock_master.sv
// TMSS unlock sequencer: writes the SEGA signature and then the lock bit
// through tmss_bus_wr, reporting done or a sticky timeout error.
module tmss_unlock_master
  import tmss_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic        MCLK,
  input  logic        RESn,
  input  logic        start,
  input  logic        cart_sel,
  input  logic        DTACK,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic [22:0] VA,
  output logic [15:0] VD_o,
  output logic        VD_oe,
  output logic        busy,
  output logic        done,
  output logic        error
);

  // state | meaning
  // IDLE  | waiting for start
  // ADDR  | a write of op0..op2 is in flight in tmss_bus_wr
  // DONE  | all three writes acknowledged, done pulse
  // ABORT | a write timed out, error raised

  tmss_state_e state, state_next;
  logic [1:0]  op, op_next;
  logic        cart_q;
  logic        accept, last_op, go;
  logic        wr_ok, wr_tmo;
  tmss_op_t    op_cfg;

  assign accept  = (state == IDLE) && start;
  assign last_op = (op == OP_LAST);
  // Next op is handed to the bus engine in the same edge the previous one releases.
  assign go      = accept || (wr_ok && !last_op);
  assign op_next = accept ? 2'd0 : ((wr_ok && !last_op) ? op + 2'd1 : op);
  assign op_cfg  = tmss_op_decode(op_next, accept ? cart_sel : cart_q);

  tmss_bus_wr #(
    .SETUP_CYC (SETUP_CYC),
    .TIMEOUT   (TIMEOUT)
  ) u_bus_wr (
    .MCLK   (MCLK),
    .RESn   (RESn),
    .go     (go),
    .op_cfg (op_cfg),
    .DTACK  (DTACK),
    .AS     (AS),
    .UDS    (UDS),
    .LDS    (LDS),
    .RW     (RW),
    .VA     (VA),
    .VD_o   (VD_o),
    .VD_oe  (VD_oe),
    .wr_ok  (wr_ok),
    .wr_tmo (wr_tmo)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) state_next = ADDR;
      end
      ADDR: begin
        if (wr_tmo)                state_next = ABORT;
        else if (wr_ok && last_op) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge RESn) begin
    if (!RESn) begin
      state  <= IDLE;
      op     <= 2'd0;
      cart_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      state <= state_next;
      op    <= op_next;
      if (accept) cart_q <= cart_sel;
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      if (accept)                    error <= 1'b0;
      else if (state_next == ABORT)  error <= 1'b1;
    end
  end

endmodule

// File: doc/tmss_unlock_master.md
TMSS_UNLOCK_MASTER -- requirements
Module: tmss_unlock_master

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, meaning cycles VA/VD are driven before strobes assert (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning max MCLK cycles to wait on any DTACK edge (legal range 1..65535).
REQ-003 SHALL have one clock and an asynchronous active-low reset: MCLK in 1 (the only clock); RESn in 1 (asynchronous, active-low).
REQ-004 start in 1: single-cycle request to run the unlock sequence.
REQ-005 cart_sel in 1: value written to bit 0 of lock register; sampled at the accepted start.
REQ-006 DTACK in 1: active-low acknowledge from the responder, same MCLK domain.
REQ-007 AS, UDS, LDS out 1 each: active-low bus strobes.
REQ-008 RW out 1: 1 = read, 0 = write.
REQ-009 VA out 23: word address A23..A1.
REQ-010 VD_o out 16: write data.
REQ-011 VD_oe out 1: high while VD_o is driven.
REQ-012 busy out 1; done out 1 (one-cycle pulse); error out 1 (sticky).

Function
REQ-013 SHALL issue three write cycles in order:
- op0: VA=0x50A000, VD=0x5345, UDS=LDS=0.
- op1: VA=0x50A001, VD=0x4741, UDS=LDS=0.
- op2: VA=0x50A080, VD={15'b0,cart_sel}, LDS=0, UDS=1.
REQ-014 SHALL use FSM states IDLE, ADDR, ASSERT, RELEASE, DONE, ABORT.
REQ-015 IDLE: start=1 at an edge SHALL go to ADDR with op=0, busy=1, error cleared, cart_sel latched.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 ADDR: VA/VD/RW=0/VD_oe=1 driven; AS/UDS/LDS high; SHALL stay exactly SETUP_CYC cycles, then go to ASSERT.
REQ-018 ASSERT: AS=0 and op strobes=0, with VA/VD held.
- DTACK=0 sampled at an edge SHALL go to RELEASE.
REQ-019 RELEASE: all strobes high, VA/VD/VD_oe held.
- DTACK=1 sampled at an edge with op<2 SHALL increment op and go to ADDR.
- Same condition with op=2 SHALL go to DONE.
REQ-020 Timeout counter SHALL clear on entry to ASSERT and to RELEASE, and increment each cycle in those states.
- Reaching TIMEOUT SHALL go to ABORT.
- Counter width SHALL be clog2(TIMEOUT+1) and it SHALL saturate.
REQ-021 DONE: done=1 for one cycle, then IDLE with busy=0.
REQ-022 ABORT: strobes high, VD_oe=0, error=1 (held until next accepted start), then IDLE with busy=0; done SHALL NOT pulse.
REQ-023 DTACK and timeout reaching TIMEOUT in the same cycle: DTACK SHALL win.
REQ-024 RW SHALL be 1 and VD_oe 0 whenever state is IDLE, DONE or ABORT.
REQ-025 All outputs SHALL be registered; no combinational path from DTACK to any output.

Reset
REQ-026 RESn low SHALL asynchronously force:
- state IDLE;
- AS=UDS=LDS=RW=1;
- VA=0, VD_o=0, VD_oe=0;
- busy=done=error=0; op=0; counter=0.
REQ-027 Reset asserted mid-sequence SHALL abort without a done or error pulse; release SHALL wait for a new start.

Structure
REQ-028 Package tmss_pkg SHALL hold:
- the state enum;
- address constants TMSS_VA_SEGA_HI=0x50A000, TMSS_VA_SEGA_LO=0x50A001, TMSS_VA_LOCK=0x50A080;
- data constants 0x5345 and 0x4741.
REQ-029 Sub-module tmss_bus_wr SHALL implement the single write cycle: ADDR/ASSERT/RELEASE, timeout, and ok/timeout result.
- The top SHALL sequence op0..op2 through it.

Verification
REQ-030 SETUP_CYC=2, responder DTACK=AS|LDS (combinational), start at edge 0 -> each op 4 cycles; done=1 in cycle 13; error=0; lock bit written = cart_sel.
REQ-031 DTACK held high -> ASSERT of op0 lasts TIMEOUT cycles, then error=1, busy=0, strobes high, no done.
REQ-032 DTACK stuck low after first ack -> RELEASE times out; error=1, op1 never asserts AS.
REQ-033 RESn pulsed low during op1 ASSERT -> strobes high within the same cycle, busy=0, error=0; new start then runs the full sequence.
REQ-034 start re-pulsed during op0 and op2 -> ignored; exactly three write cycles observed; start after error -> error cleared.
REQ-035 cart_sel=1 with the tmss responder attached, JAP=0 -> RESET output released and CE0 routing follows the lock bit after done.
